dmem_ctrl: RTL and testbench
============================

DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 Parameter: none; all data and address paths SHALL be 32 bits, word-addressed, little-endian.
REQ-002 The block SHALL have one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  rising-edge clock shared with the pipeline.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 MemWriteM  input  1  Memory-stage store request.
REQ-006 MemReadM  input  1  Memory-stage load request.
REQ-007 ALUOutM  input  32  Memory-stage byte address.
REQ-008 WriteDataM  input  32  store data.
REQ-009 ReadDataM  output  32  load data to the writeback register.
REQ-010 MemStallM  output  1  request to the hazard unit to hold the F, D, E and M stages.
REQ-011 AlignErrM  output  1  misaligned-access flag for the current M-stage access.
REQ-012 bus_req  output  1  backing-memory request, registered.
REQ-013 bus_we  output  1  backing-memory write enable, registered.
REQ-014 bus_addr  output  32  word-aligned backing-memory address, registered.
REQ-015 bus_wdata  output  32  backing-memory write data, registered.
REQ-016 bus_ack  input  1  backing-memory completion, one cycle per transfer.
REQ-017 bus_rdata  input  32  backing-memory read data, valid when bus_ack=1.

Function
REQ-018 The FSM SHALL have four states: IDLE, DRAIN (write-buffer write in flight), RBUSY (read in flight) and RDONE (load data presented).
REQ-019 The block SHALL hold a one-entry write buffer: wb_valid, wb_addr[31:2] and wb_data.
REQ-020 Access words SHALL be formed from ALUOutM[31:2]; bus_addr[1:0] SHALL always be 0.
REQ-021 AlignErrM SHALL be combinationally 1 whenever (MemReadM|MemWriteM) & (ALUOutM[1:0]!=0); the access proceeds with the low bits ignored.
REQ-022 If MemWriteM and MemReadM are both 1, the access SHALL be treated as a store only.
REQ-023 Store, buffer empty, state IDLE or RDONE: MemStallM SHALL be 0, and the entry SHALL be captured at the clock edge (wb_valid set to 1).
REQ-024 Store, wb_valid=1: MemStallM SHALL be 1 until the buffer frees; the capture occurs only in the cycle MemStallM=0.
REQ-025 In IDLE with wb_valid=1 and no load hit/RDONE pending, the FSM SHALL go to DRAIN on the next edge, with bus_req=1, bus_we=1 and addr/data taken from the buffer.
REQ-026 In DRAIN, the bus_* outputs SHALL hold stable until bus_ack.
REQ-027 On bus_ack in DRAIN: wb_valid SHALL be cleared, bus_req SHALL be 0 from the next cycle, and the FSM SHALL return to IDLE.
REQ-028 Load hit: if wb_valid=1 and wb_addr matches ALUOutM[31:2], ReadDataM SHALL be wb_data combinationally and MemStallM SHALL be 0; no bus access occurs.
REQ-029 Load miss, wb_valid=1: MemStallM SHALL be 1; the buffer drains first, so store-before-load ordering is preserved.
REQ-030 Load miss, buffer empty, IDLE: MemStallM SHALL be 1 and the FSM SHALL go to RBUSY with bus_req=1 and bus_we=0.
REQ-031 In RBUSY, MemStallM SHALL remain 1.
REQ-032 On bus_ack in RBUSY, bus_rdata SHALL be latched into rdata_q and the FSM SHALL go to RDONE.
REQ-033 In RDONE: MemStallM SHALL be 0, ReadDataM SHALL equal rdata_q, and the FSM SHALL return to IDLE next edge.
REQ-034 Minimum load-miss stall SHALL be 2 cycles; stall SHALL equal 1 + cycles from bus_req rise to bus_ack.
REQ-035 bus_ack SHALL be ignored while bus_req=0.
REQ-036 ReadDataM SHALL be 0 when no load hit and the FSM is not in RDONE.
REQ-037 MemStallM SHALL be 0 whenever MemReadM=MemWriteM=0, except that the drain continues in the background.

Reset
REQ-038 At a reset edge: state SHALL become IDLE, and wb_valid, bus_req, bus_we, bus_addr, bus_wdata and rdata_q SHALL be 0.
REQ-039 While reset is high, MemStallM SHALL be 0 regardless of inputs.
REQ-040 Reset mid-DRAIN or mid-RBUSY SHALL abandon the transfer: the buffered store is discarded and a late bus_ack is ignored.

Verification
REQ-041 Store 0xDEADBEEF to 0x100, buffer empty, ack after 3 cycles -> MemStallM=0 at issue; bus write (0x100, 0xDEADBEEF) held 3 cycles; wb_valid clears.
REQ-042 Store to 0x100 then load 0x100 the next cycle -> ReadDataM=0xDEADBEEF same cycle, MemStallM=0, no bus read.
REQ-043 Store to 0x100 then load 0x200, ack=1 cycle -> drain write completes first, then read of 0x200; load stalls until RDONE presents bus_rdata.
REQ-044 Two back-to-back stores, slow ack (5 cycles) -> the second store stalls until the first ack, then is captured; the bus sees the writes in order.
REQ-045 Load 0x103 -> AlignErrM=1, bus_addr=0x100.
REQ-046 Reset asserted during RBUSY, then bus_ack arrives -> bus_req=0, state IDLE, rdata_q=0, MemStallM=0.

Source files
------------

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: data-memory controller for the M stage of the pipeline.
// Holds a one-entry write buffer so stores retire without stalling,
// forwards buffered data to a matching load, and fetches load misses
// from a single-outstanding backing-memory bus.
//
// Ports
//   clk, reset              rising-edge clock, synchronous active-high reset
//   MemWriteM, MemReadM     M-stage store / load request
//   ALUOutM                 byte address (word access, low two bits ignored)
//   WriteDataM              store data
//   ReadDataM               load data to writeback (combinational)
//   MemStallM               hold request to the hazard unit (combinational)
//   AlignErrM               misaligned-access flag (combinational)
//   bus_req/we/addr/wdata   registered backing-memory request
//   bus_ack, bus_rdata      backing-memory completion and read data
module dmem_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWriteM,
    input  logic        MemReadM,
    input  logic [31:0] ALUOutM,
    input  logic [31:0] WriteDataM,
    output logic [31:0] ReadDataM,
    output logic        MemStallM,
    output logic        AlignErrM,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    localparam int unsigned XLEN    = 32;
    localparam int unsigned WADDR_W = 30;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        RBUSY = 2'd2,
        RDONE = 2'd3
    } state_t;

    state_t              state;
    logic                wb_valid;
    logic [WADDR_W-1:0]  wb_addr;
    logic [XLEN-1:0]     wb_data;
    logic [XLEN-1:0]     rdata_q;

    logic [WADDR_W-1:0]  word_addr;
    logic                is_store;
    logic                is_load;
    logic                load_hit;
    logic                acked;
    logic                capture;

    // A simultaneous read+write request is a store only.
    assign word_addr = ALUOutM[31:2];
    assign is_store  = MemWriteM;
    assign is_load   = MemReadM & ~MemWriteM;
    assign load_hit  = is_load & wb_valid & (wb_addr == word_addr);
    assign acked     = bus_req & bus_ack;
    assign capture   = is_store & ~MemStallM;

    assign AlignErrM = (MemReadM | MemWriteM) & (ALUOutM[1:0] != 2'b00);

    // Stall: store waits for a free buffer; load waits unless it hits or is being presented.
    always_comb begin
        MemStallM = 1'b0;
        if (!reset) begin
            if (is_store) begin
                MemStallM = wb_valid | (state == RBUSY);
            end else if (is_load) begin
                MemStallM = !load_hit && (state != RDONE);
            end
        end
    end

    // Load data: forwarded buffer entry, else fetched word while presented, else zero.
    always_comb begin
        ReadDataM = '0;
        if (load_hit) begin
            ReadDataM = wb_data;
        end else if (state == RDONE) begin
            ReadDataM = rdata_q;
        end
    end

    // Controller FSM, write buffer and registered bus outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            wb_valid  <= 1'b0;
            wb_addr   <= '0;
            wb_data   <= '0;
            rdata_q   <= '0;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
        end else begin
            if (capture) begin
                wb_valid <= 1'b1;
                wb_addr  <= word_addr;
                wb_data  <= WriteDataM;
            end
            case (state)
                IDLE: begin
                    // Draining first keeps store-before-load ordering on a miss.
                    if (wb_valid && !load_hit) begin
                        state     <= DRAIN;
                        bus_req   <= 1'b1;
                        bus_we    <= 1'b1;
                        bus_addr  <= {wb_addr, 2'b00};
                        bus_wdata <= wb_data;
                    end else if (is_load && !load_hit) begin
                        state    <= RBUSY;
                        bus_req  <= 1'b1;
                        bus_we   <= 1'b0;
                        bus_addr <= {word_addr, 2'b00};
                    end
                end
                DRAIN: begin
                    if (acked) begin
                        state    <= IDLE;
                        bus_req  <= 1'b0;
                        bus_we   <= 1'b0;
                        wb_valid <= 1'b0;
                    end
                end
                RBUSY: begin
                    if (acked) begin
                        state   <= RDONE;
                        bus_req <= 1'b0;
                        rdata_q <= bus_rdata;
                    end
                end
                RDONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: directed bench for dmem_ctrl with a latency-programmable
// backing-memory responder that logs every completed transfer.
module tb_dmem_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemWriteM;
    logic        MemReadM;
    logic [31:0] ALUOutM;
    logic [31:0] WriteDataM;
    logic [31:0] ReadDataM;
    logic        MemStallM;
    logic        AlignErrM;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    int vectors    = 0;
    int miscompares = 0;

    // Responder state
    int          ack_lat = 1;
    logic        auto_ack = 1'b0;
    logic        force_ack = 1'b0;
    int          cnt = 0;
    int          hold_err = 0;
    int          n_log = 0;
    logic        log_we   [32];
    logic [31:0] log_addr [32];
    logic [31:0] log_data [32];
    int          log_len  [32];
    logic        p_we;
    logic [31:0] p_addr;
    logic [31:0] p_wdata;

    assign bus_ack = auto_ack | force_ack;

    dmem_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .MemWriteM  (MemWriteM),
        .MemReadM   (MemReadM),
        .ALUOutM    (ALUOutM),
        .WriteDataM (WriteDataM),
        .ReadDataM  (ReadDataM),
        .MemStallM  (MemStallM),
        .AlignErrM  (AlignErrM),
        .bus_req    (bus_req),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_ack    (bus_ack),
        .bus_rdata  (bus_rdata)
    );

    initial forever #5 clk = ~clk;

    // Backing memory: ack after ack_lat cycles of bus_req, read data = {C0DE, addr[15:0]}.
    initial begin
        bus_rdata = 32'h0;
        p_we = 1'b0; p_addr = 32'h0; p_wdata = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            if (bus_req === 1'b1) begin
                cnt = cnt + 1;
                if (cnt > 1 && (bus_we !== p_we || bus_addr !== p_addr || bus_wdata !== p_wdata))
                    hold_err = hold_err + 1;
                p_we = bus_we; p_addr = bus_addr; p_wdata = bus_wdata;
                bus_rdata = {16'hC0DE, bus_addr[15:0]};
                if (cnt == ack_lat) begin
                    auto_ack = 1'b1;
                    if (n_log < 32) begin
                        log_we[n_log]   = bus_we;
                        log_addr[n_log] = bus_addr;
                        log_data[n_log] = bus_wdata;
                        log_len[n_log]  = cnt;
                    end
                    n_log = n_log + 1;
                end else begin
                    auto_ack = 1'b0;
                end
            end else begin
                cnt = 0;
                auto_ack = 1'b0;
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        MemWriteM = 1'b0; MemReadM = 1'b0; ALUOutM = 32'h0; WriteDataM = 32'h0;
    endtask

    // Called at mid-cycle; counts consecutive stalled cycles.
    task automatic count_stall(output int n, output bit ok);
        n = 0; ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (MemStallM !== 1'b1) begin ok = 1'b1; break; end
            n = n + 1;
            next_cycle(); #1;
        end
    endtask

    // Called at mid-cycle; waits until the responder has logged target transfers.
    task automatic wait_log(input int target, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (n_log >= target) begin ok = 1'b1; break; end
            next_cycle(); #1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; idle_inputs();
        repeat (2) next_cycle();
        MemReadM = 1'b1; ALUOutM = 32'h200;
        #1;
        vectors++; if (MemStallM !== 1'b0) begin miscompares++; $display("FAIL reset_stall: got %b expected 0", MemStallM); end
        next_cycle();
        reset = 1'b0; idle_inputs();
        #1;
        vectors++; if (bus_req !== 1'b0) begin miscompares++; $display("FAIL reset_bus_req: got %b expected 0", bus_req); end
        vectors++; if (bus_we !== 1'b0) begin miscompares++; $display("FAIL reset_bus_we: got %b expected 0", bus_we); end
        vectors++; if (bus_addr !== 32'h0) begin miscompares++; $display("FAIL reset_bus_addr: got %h expected 0", bus_addr); end
        vectors++; if (bus_wdata !== 32'h0) begin miscompares++; $display("FAIL reset_bus_wdata: got %h expected 0", bus_wdata); end
        vectors++; if (ReadDataM !== 32'h0) begin miscompares++; $display("FAIL reset_rdata: got %h expected 0", ReadDataM); end
        vectors++; if (2'(dut.state) !== 2'd0) begin miscompares++; $display("FAIL reset_state: got %0d expected 0", 2'(dut.state)); end
    endtask

    task automatic test_store();
        int base; bit ok;
        ack_lat = 3; base = n_log;
        next_cycle();
        MemWriteM = 1'b1; ALUOutM = 32'h100; WriteDataM = 32'hDEADBEEF;
        #1;
        vectors++; if (MemStallM !== 1'b0) begin miscompares++; $display("FAIL st_issue_stall: got %b expected 0", MemStallM); end
        vectors++; if (AlignErrM !== 1'b0) begin miscompares++; $display("FAIL st_align: got %b expected 0", AlignErrM); end
        next_cycle(); idle_inputs(); #1;
        wait_log(base + 1, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL st_timeout: got %0d transfers expected %0d", n_log - base, 1); end
        next_cycle(); #1;
        vectors++; if (bus_req !== 1'b0) begin miscompares++; $display("FAIL st_req_drop: got %b expected 0", bus_req); end
        vectors++; if (dut.wb_valid !== 1'b0) begin miscompares++; $display("FAIL st_wb_clear: got %b expected 0", dut.wb_valid); end
        if (ok) begin
            vectors++; if (log_we[base] !== 1'b1 || log_addr[base] !== 32'h100 || log_data[base] !== 32'hDEADBEEF) begin
                miscompares++; $display("FAIL st_bus_write: got we=%b %h/%h expected we=1 00000100/deadbeef", log_we[base], log_addr[base], log_data[base]); end
            vectors++; if (log_len[base] != 3) begin miscompares++; $display("FAIL st_hold_cycles: got %0d expected 3", log_len[base]); end
        end
        vectors++; if (hold_err != 0) begin miscompares++; $display("FAIL st_bus_stable: got %0d changes expected 0", hold_err); end
    endtask

    task automatic test_load_hit();
        int base; bit ok;
        ack_lat = 1; base = n_log;
        next_cycle();
        MemWriteM = 1'b1; ALUOutM = 32'h100; WriteDataM = 32'hDEADBEEF;
        next_cycle();
        MemWriteM = 1'b0; MemReadM = 1'b1; ALUOutM = 32'h100;
        #1;
        vectors++; if (ReadDataM !== 32'hDEADBEEF) begin miscompares++; $display("FAIL hit_data: got %h expected deadbeef", ReadDataM); end
        vectors++; if (MemStallM !== 1'b0) begin miscompares++; $display("FAIL hit_stall: got %b expected 0", MemStallM); end
        next_cycle(); idle_inputs(); #1;
        wait_log(base + 1, ok);
        next_cycle(); #1;
        vectors++; if (!ok || n_log != base + 1 || log_we[base] !== 1'b1) begin
            miscompares++; $display("FAIL hit_no_read: got %0d transfers first_we=%b expected 1 transfer we=1", n_log - base, log_we[base]); end
    endtask

    task automatic test_store_load_miss();
        int base; int n; bit ok;
        ack_lat = 1; base = n_log;
        next_cycle();
        MemWriteM = 1'b1; ALUOutM = 32'h100; WriteDataM = 32'h12345678;
        next_cycle();
        MemWriteM = 1'b0; MemReadM = 1'b1; ALUOutM = 32'h200;
        #1;
        count_stall(n, ok);
        vectors++; if (!ok || n != 4) begin miscompares++; $display("FAIL slm_stall: got %0d cycles expected 4", n); end
        vectors++; if (ReadDataM !== 32'hC0DE0200) begin miscompares++; $display("FAIL slm_data: got %h expected c0de0200", ReadDataM); end
        vectors++; if (n_log < base + 2 || log_we[base] !== 1'b1 || log_addr[base] !== 32'h100 || log_data[base] !== 32'h12345678
                       || log_we[base+1] !== 1'b0 || log_addr[base+1] !== 32'h200) begin
            miscompares++; $display("FAIL slm_order: got %0d transfers, first we=%b %h expected write 00000100 then read 00000200", n_log - base, log_we[base], log_addr[base]); end
        next_cycle(); idle_inputs(); #1;
        vectors++; if (ReadDataM !== 32'h0) begin miscompares++; $display("FAIL slm_rdata_idle: got %h expected 0", ReadDataM); end
        vectors++; if (MemStallM !== 1'b0) begin miscompares++; $display("FAIL slm_stall_idle: got %b expected 0", MemStallM); end
    endtask

    task automatic test_load_miss();
        int          lat_t  [2] = '{1, 3};
        logic [31:0] addr_t [2] = '{32'h300, 32'h304};
        int          stall_t[2] = '{2, 4};
        logic [31:0] data_t [2] = '{32'hC0DE0300, 32'hC0DE0304};
        int n; bit ok;
        for (int k = 0; k < 2; k++) begin
            ack_lat = lat_t[k];
            next_cycle();
            MemReadM = 1'b1; ALUOutM = addr_t[k];
            #1;
            count_stall(n, ok);
            vectors++; if (!ok || n != stall_t[k]) begin miscompares++; $display("FAIL lm_stall_lat%0d: got %0d expected %0d", lat_t[k], n, stall_t[k]); end
            vectors++; if (ReadDataM !== data_t[k]) begin miscompares++; $display("FAIL lm_data_lat%0d: got %h expected %h", lat_t[k], ReadDataM, data_t[k]); end
            next_cycle(); idle_inputs();
        end
    endtask

    task automatic test_back_to_back();
        int base; int n; bit ok;
        ack_lat = 5; base = n_log;
        next_cycle();
        MemWriteM = 1'b1; ALUOutM = 32'h100; WriteDataM = 32'hAAAA0001;
        #1;
        vectors++; if (MemStallM !== 1'b0) begin miscompares++; $display("FAIL b2b_first_stall: got %b expected 0", MemStallM); end
        next_cycle();
        ALUOutM = 32'h104; WriteDataM = 32'hBBBB0002;
        #1;
        count_stall(n, ok);
        vectors++; if (!ok || n != 6) begin miscompares++; $display("FAIL b2b_stall: got %0d cycles expected 6", n); end
        next_cycle(); idle_inputs(); #1;
        wait_log(base + 2, ok);
        next_cycle(); #1;
        vectors++; if (!ok || log_addr[base] !== 32'h100 || log_data[base] !== 32'hAAAA0001 || log_we[base] !== 1'b1
                       || log_addr[base+1] !== 32'h104 || log_data[base+1] !== 32'hBBBB0002 || log_we[base+1] !== 1'b1) begin
            miscompares++; $display("FAIL b2b_order: got %0d transfers first %h/%h expected 00000100/aaaa0001 then 00000104/bbbb0002", n_log - base, log_addr[base], log_data[base]); end
        vectors++; if (hold_err != 0) begin miscompares++; $display("FAIL b2b_bus_stable: got %0d changes expected 0", hold_err); end
    endtask

    task automatic test_align();
        int n; bit ok;
        ack_lat = 1;
        next_cycle();
        MemReadM = 1'b1; ALUOutM = 32'h103;
        #1;
        vectors++; if (AlignErrM !== 1'b1) begin miscompares++; $display("FAIL al_flag: got %b expected 1", AlignErrM); end
        vectors++; if (MemStallM !== 1'b1) begin miscompares++; $display("FAIL al_stall: got %b expected 1", MemStallM); end
        next_cycle(); #1;
        vectors++; if (bus_req !== 1'b1 || bus_we !== 1'b0 || bus_addr !== 32'h100) begin
            miscompares++; $display("FAIL al_bus_addr: got req=%b we=%b %h expected req=1 we=0 00000100", bus_req, bus_we, bus_addr); end
        count_stall(n, ok);
        vectors++; if (!ok || ReadDataM !== 32'hC0DE0100) begin miscompares++; $display("FAIL al_data: got %h expected c0de0100", ReadDataM); end
        next_cycle();
        idle_inputs(); ALUOutM = 32'h103;
        #1;
        vectors++; if (AlignErrM !== 1'b0 || MemStallM !== 1'b0) begin
            miscompares++; $display("FAIL al_no_access: got align=%b stall=%b expected 0 0", AlignErrM, MemStallM); end
        idle_inputs();
    endtask

    task automatic test_reset_rbusy();
        ack_lat = 10;
        next_cycle();
        MemReadM = 1'b1; ALUOutM = 32'h200;
        next_cycle(); #1;
        vectors++; if (bus_req !== 1'b1) begin miscompares++; $display("FAIL rr_req_busy: got %b expected 1", bus_req); end
        next_cycle();
        reset = 1'b1;
        #1;
        vectors++; if (MemStallM !== 1'b0) begin miscompares++; $display("FAIL rr_stall_in_reset: got %b expected 0", MemStallM); end
        next_cycle();
        reset = 1'b0; idle_inputs(); force_ack = 1'b1;
        #1;
        vectors++; if (bus_req !== 1'b0) begin miscompares++; $display("FAIL rr_req_drop: got %b expected 0", bus_req); end
        next_cycle();
        force_ack = 1'b0;
        #1;
        vectors++; if (2'(dut.state) !== 2'd0) begin miscompares++; $display("FAIL rr_state: got %0d expected 0", 2'(dut.state)); end
        vectors++; if (dut.rdata_q !== 32'h0) begin miscompares++; $display("FAIL rr_rdata_q: got %h expected 0", dut.rdata_q); end
        vectors++; if (bus_req !== 1'b0 || MemStallM !== 1'b0 || ReadDataM !== 32'h0) begin
            miscompares++; $display("FAIL rr_quiet: got req=%b stall=%b rdata=%h expected 0 0 0", bus_req, MemStallM, ReadDataM); end
        ack_lat = 1;
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_store();
        test_load_hit();
        test_store_load_miss();
        test_load_miss();
        test_back_to_back();
        test_align();
        test_reset_rbusy();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached with %0d vectors applied", vectors);
        $fatal(1);
    end

endmodule
